// File: rtl/adc_parallel_read_interface.sv
// adc_parallel_read_interface: parallel SAR ADC conversion/readout sequencer.
// Optional busy watchdog enabled by defining ADC_BUSY_TIMEOUT_EN.
//
// Purpose:
//   Pulses CONVST, masks then waits on the synchronized ADC BUSY, drives
//   CS_N/RD_N low for RD_CYCLES clocks, captures the data bus as RD_N
//   rises and presents it with a one-cycle data_valid pulse.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   start      1-cycle conversion request, honoured only when idle
//   adc_busy   asynchronous ADC BUSY (2-flop synchronized internally)
//   adc_data   ADC parallel data bus
//   convst     conversion-start strobe, active high
//   cs_n       ADC chip select, active low
//   rd_n       ADC read enable, active low
//   data_out   last captured sample
//   data_valid 1-cycle pulse when data_out updates
//   busy       high from accepted start until capture or abort
//   timeout    1-cycle pulse on watchdog abort (0 without the watchdog)

module adc_parallel_read_interface #(
  parameter int DATA_WIDTH       = 16,
  parameter int CONVST_CYCLES    = 2,
  parameter int BUSY_MASK_CYCLES = 4,
  parameter int RD_CYCLES        = 3,
  parameter int TIMEOUT_CYCLES   = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  adc_busy,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic                  convst,
  output logic                  cs_n,
  output logic                  rd_n,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVST,
    S_CONV,
    S_READ
  } state_t;

  localparam logic [7:0] LP_CV = 8'(CONVST_CYCLES - 1);
  localparam logic [7:0] LP_BM = 8'(BUSY_MASK_CYCLES);
  localparam logic [7:0] LP_RD = 8'(RD_CYCLES - 1);

  state_t                r_state;
  logic [7:0]            r_cnt;
  logic [1:0]            r_sync;
  logic                  r_convst;
  logic                  r_cs_n;
  logic                  r_rd_n;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_dv;
  logic                  r_busy;
  logic                  w_busy_s;

`ifdef ADC_BUSY_TIMEOUT_EN
  localparam logic [15:0] LP_TO = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0]           r_wd;
  logic                  r_to;
`endif

  assign w_busy_s = r_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sync   <= '0;
      r_convst <= 1'b0;
      r_cs_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_data   <= '0;
      r_dv     <= 1'b0;
      r_busy   <= 1'b0;
`ifdef ADC_BUSY_TIMEOUT_EN
      r_wd     <= '0;
      r_to     <= 1'b0;
`endif
    end else begin
      r_sync <= {r_sync[0], adc_busy};
      // Pulses only ever last one cycle: they are set on the
      // way into IDLE and dropped on the next edge.
      r_dv   <= 1'b0;
`ifdef ADC_BUSY_TIMEOUT_EN
      r_to   <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_convst <= 1'b1;
            r_busy   <= 1'b1;
            r_cnt    <= LP_CV;
            r_state  <= S_CONVST;
          end
        end
        S_CONVST: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_convst <= 1'b0;
            r_cnt    <= LP_BM;
`ifdef ADC_BUSY_TIMEOUT_EN
            r_wd     <= '0;
`endif
            r_state  <= S_CONV;
          end
        end
        S_CONV: begin
          // The mask covers the synchronizer plus the ADC's own
          // BUSY rise delay; a stale low busy_s must not be trusted.
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (!w_busy_s) begin
            r_cs_n  <= 1'b0;
            r_rd_n  <= 1'b0;
            r_cnt   <= LP_RD;
            r_state <= S_READ;
          end
`ifdef ADC_BUSY_TIMEOUT_EN
          else if (r_wd == LP_TO) begin
            r_to    <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
`endif
        end
        S_READ: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_data  <= adc_data;
            r_dv    <= 1'b1;
            r_cs_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign convst     = r_convst;
  assign cs_n       = r_cs_n;
  assign rd_n       = r_rd_n;
  assign data_out   = r_data;
  assign data_valid = r_dv;
  assign busy       = r_busy;
`ifdef ADC_BUSY_TIMEOUT_EN
  assign timeout    = r_to;
`else
  assign timeout    = 1'b0;
`endif

endmodule
